// File: rtl/coo_encoder.sv
// coo_encoder
//   Streams an 8x8 dense FP8 matrix (row-major, one element per accepted beat)
//   and packs its nonzero elements into a coordinate-list (COO) buffer of
//   MAX_NNZ entries. Once all 64 positions have been seen, the buffer is
//   frozen (done=1) until the downstream consumer acknowledges it.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream element present
//   in_ready   : encoder accepts an element this cycle (FILL state)
//   in_data    : FP8 element {sign, exp[3:0], mant[2:0]}
//   out_ack    : consumer has taken the buffer (honoured only while done=1)
//   done       : buffer holds a complete encoded matrix (HOLD state)
//   coo_data   : per-entry element value
//   coo_row    : per-entry row index
//   coo_col    : per-entry column index
//   coo_valid  : per-entry valid flag; entries nnz..MAX_NNZ-1 read 0
//   nnz        : number of valid entries
//   overflow   : sticky, more nonzeros arrived than the buffer holds
//
// Build option
//   COO_SUBNORM_FLUSH_EN : when defined, any element whose exponent field is
//                          zero (zeros and subnormals) is treated as zero.

module coo_encoder #(
  parameter int MAX_NNZ = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       out_ack,
  output logic       done,
  output logic [7:0] coo_data  [MAX_NNZ],
  output logic [2:0] coo_row   [MAX_NNZ],
  output logic [2:0] coo_col   [MAX_NNZ],
  output logic       coo_valid [MAX_NNZ],
  output logic [6:0] nnz,
  output logic       overflow
);

  localparam logic [6:0] MAX_NNZ_W = 7'(MAX_NNZ);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] pos_q, pos_d;
  logic [6:0] nnz_q, nnz_d;
  logic       overflow_q, overflow_d;

  logic is_zero;
  logic accept;
  logic store;
  logic clear;

  // Zero classification; the sign bit never matters.
`ifdef COO_SUBNORM_FLUSH_EN
  assign is_zero = (in_data[6:3] == 4'd0);
`else
  assign is_zero = (in_data[6:0] == 7'd0);
`endif

  assign accept = in_valid && (state_q == FILL);
  // A nonzero that finds the buffer full is dropped and only raises overflow.
  assign store  = accept && !is_zero && (nnz_q < MAX_NNZ_W);
  assign clear  = (state_q == HOLD) && out_ack;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    nnz_d      = nnz_q;
    overflow_d = overflow_q;
    if (clear) begin
      state_d    = FILL;
      nnz_d      = 7'd0;
      overflow_d = 1'b0;
    end else if (accept) begin
      // pos wraps naturally from 63 to 0 on the last element.
      pos_d = pos_q + 6'd1;
      if (store) begin
        nnz_d = nnz_q + 7'd1;
      end else if (!is_zero) begin
        overflow_d = 1'b1;
      end
      if (pos_q == 6'd63) begin
        state_d = HOLD;
      end
    end
  end

  // FSM and control state; in_ready/done decode directly from the state flop
  // so both are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      pos_q      <= 6'd0;
      nnz_q      <= 7'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      nnz_q      <= nnz_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready = (state_q == FILL);
  assign done     = (state_q == HOLD);
  assign nnz      = nnz_q;
  assign overflow = overflow_q;

  // One storage slot per buffer entry. Slot gi is written only when it is the
  // next free index, which keeps entries packed in ascending order.
  for (genvar gi = 0; gi < MAX_NNZ; gi++) begin : g_entry
    logic [7:0] data_q, data_d;
    logic [2:0] row_q, row_d;
    logic [2:0] col_q, col_d;
    logic       valid_q, valid_d;

    always_comb begin
      data_d  = data_q;
      row_d   = row_q;
      col_d   = col_q;
      valid_d = valid_q;
      if (clear) begin
        valid_d = 1'b0;
      end else if (store && (nnz_q == 7'(gi))) begin
        data_d  = in_data;
        row_d   = pos_q[5:3];
        col_d   = pos_q[2:0];
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= 8'd0;
        row_q   <= 3'd0;
        col_q   <= 3'd0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        row_q   <= row_d;
        col_q   <= col_d;
        valid_q <= valid_d;
      end
    end

    assign coo_data[gi]  = data_q;
    assign coo_row[gi]   = row_q;
    assign coo_col[gi]   = col_q;
    assign coo_valid[gi] = valid_q;
  end

endmodule
